// File: rtl/dac_sample_source_if.sv
// dac_sample_source_if
//   Demultiplexed amplifier sample stream feeding the DAC sample source.
//
//   Handshake: sample_valid is a one-cycle strobe qualifying sample_in,
//   sample_stream and sample_channel on the same dataclk edge. There is no
//   ready/backpressure; the consumer must accept every strobe.
//
//   Signals:
//     sample_in       16  amplifier sample, offset binary (0x8000 = 0 V)
//     sample_valid     1  strobe qualifying the other three fields
//     sample_stream    5  stream index of sample_in
//     sample_channel   5  amplifier channel index of sample_in
//
//   Modports: master drives the stream, slave (the DAC source) observes it.
interface dac_sample_source_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [4:0]  sample_stream;
    logic [4:0]  sample_channel;

    modport master (
        output sample_in,
        output sample_valid,
        output sample_stream,
        output sample_channel
    );

    modport slave (
        input sample_in,
        input sample_valid,
        input sample_stream,
        input sample_channel
    );
endinterface

// File: rtl/dac_sample_source.sv
// dac_sample_source
//   Produces the 16-bit word shifted out by the AD5662 SPI serializer.
//   Captures one selected stream/channel from the amplifier sample stream
//   (or the host manual value), applies left-shift gain with saturation and
//   an optional noise deadband, then double-buffers the result so that
//   DAC_register only changes at a frame boundary (main_state == ms_wait,
//   channel == 0) and never in the middle of an SPI frame.
//
//   Pipeline: capture (x1) -> gain/saturate (x2) -> deadband -> pending.
//   A matching strobe reaches pending exactly 3 dataclk edges later.
//
//   Ports:
//     dataclk, reset       clock, asynchronous active-high reset
//     main_state, channel  global sequencer state / channel counter
//     sample_bus           sample stream (dac_sample_source_if.slave)
//     stream_sel           selected stream; MANUAL_SEL selects DAC_manual
//     channel_sel          selected channel
//     DAC_manual           host-written manual value (offset binary)
//     gain                 left-shift gain 0..7
//     noise_suppress       deadband half-width in units of 16 LSB
//     hold_off             (only with DAC_SAMPLE_HOLDOFF_EN) suppresses commits
//     DAC_register         committed word for the SPI stage
//     DAC_update           one-cycle pulse on every commit
//
//   Optional feature: define DAC_SAMPLE_HOLDOFF_EN to add the hold_off input.
module dac_sample_source #(
    parameter logic [31:0] ms_wait    = 32'd99,
    parameter logic [4:0]  MANUAL_SEL = 5'd31
) (
    input  logic                      dataclk,
    input  logic                      reset,
    input  logic [31:0]               main_state,
    input  logic [5:0]                channel,
    dac_sample_source_if.slave        sample_bus,
    input  logic [4:0]                stream_sel,
    input  logic [4:0]                channel_sel,
    input  logic [15:0]               DAC_manual,
    input  logic [2:0]                gain,
    input  logic [6:0]                noise_suppress,
`ifdef DAC_SAMPLE_HOLDOFF_EN
    input  logic                      hold_off,
`endif
    output logic [15:0]               DAC_register,
    output logic                      DAC_update
);

    // ------------------------------------------------------------------
    // Frame boundary and capture qualification
    // ------------------------------------------------------------------
    logic        frame_point;
    logic        manual_mode;
    logic        capture_match;
    logic        inject;
    logic        s1_load;
    logic [15:0] s1_x_next;

    assign frame_point   = (main_state == ms_wait) && (channel == 6'd0);
    assign manual_mode   = (stream_sel == MANUAL_SEL);
    assign capture_match = !manual_mode && sample_bus.sample_valid &&
                           (sample_bus.sample_stream  == stream_sel) &&
                           (sample_bus.sample_channel == channel_sel);
    // In manual mode the host value enters the pipe once per frame.
    assign inject        = manual_mode && frame_point;
    assign s1_load       = capture_match || inject;
    // Offset binary to two's complement.
    assign s1_x_next     = (inject ? DAC_manual : sample_bus.sample_in) - 16'h8000;

    // ------------------------------------------------------------------
    // Stage 1: captured sample plus the settings it was captured with,
    // so later selection/gain changes do not affect it.
    // ------------------------------------------------------------------
    logic [15:0] s1_x;
    logic        s1_v;
    logic        s1_manual;
    logic [2:0]  s1_gain;
    logic [6:0]  s1_ns;

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            s1_x      <= 16'h8000;
            s1_v      <= 1'b0;
            s1_manual <= 1'b0;
            s1_gain   <= 3'd0;
            s1_ns     <= 7'd0;
        end else begin
            s1_v <= s1_load;
            if (s1_load) begin
                s1_x      <= s1_x_next;
                s1_manual <= inject;
                s1_gain   <= gain;
                s1_ns     <= noise_suppress;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gain at 24 bits signed, saturate to 16 bits.
    // 16-bit value shifted by at most 7 fits in 23 bits, so 24 is enough.
    // ------------------------------------------------------------------
    logic [2:0]         gain_eff;
    logic signed [23:0] wide;
    logic [15:0]        sat;

    assign gain_eff = s1_manual ? 3'd0 : s1_gain;

    always_comb begin
        wide = {{8{s1_x[15]}}, s1_x} << gain_eff;
        sat  = wide[15:0];
        if (wide > 24'sd32767) begin
            sat = 16'h7FFF;
        end else if (wide < -24'sd32768) begin
            sat = 16'h8000;
        end
    end

    logic [15:0] s2_x;
    logic        s2_v;
    logic        s2_manual;
    logic [6:0]  s2_ns;

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            s2_x      <= 16'h8000;
            s2_v      <= 1'b0;
            s2_manual <= 1'b0;
            s2_ns     <= 7'd0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_x      <= sat;
                s2_manual <= s1_manual;
                s2_ns     <= s1_ns;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: deadband. Magnitude needs 17 bits to hold |-32768|.
    // Strict less-than, so noise_suppress == 0 never zeroes anything.
    // ------------------------------------------------------------------
    logic [16:0] ext;
    logic [16:0] mag;
    logic [16:0] threshold;
    logic        dead;
    logic [15:0] x3;
    logic [15:0] pending_next;

    assign ext          = {s2_x[15], s2_x};
    assign mag          = s2_x[15] ? (~ext + 17'd1) : ext;
    assign threshold    = {6'd0, s2_ns, 4'd0};
    assign dead         = !s2_manual && (mag < threshold);
    assign x3           = dead ? 16'h0000 : s2_x;
    assign pending_next = x3 + 16'h8000;

    // ------------------------------------------------------------------
    // Pending buffer and frame-boundary commit.
    // A stage-3 write in the commit cycle: the commit takes the old pending
    // word and the new word stays pending for the next frame.
    // ------------------------------------------------------------------
    logic [15:0] pending;
    logic        pending_valid;
    logic        commit_now;

`ifdef DAC_SAMPLE_HOLDOFF_EN
    assign commit_now = frame_point && pending_valid && !hold_off;
`else
    assign commit_now = frame_point && pending_valid;
`endif

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            pending       <= 16'h8000;
            pending_valid <= 1'b0;
            DAC_register  <= 16'h8000;
            DAC_update    <= 1'b0;
        end else begin
            DAC_update <= commit_now;
            if (commit_now) begin
                DAC_register <= pending;
            end
            if (s2_v) begin
                pending       <= pending_next;
                pending_valid <= 1'b1;
            end else if (commit_now) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_source.sv
// tb_dac_sample_source
//   Self-checking bench for dac_sample_source. Expected committed words are
//   pushed to exp_q when a sample is driven and popped when the DUT pulses
//   DAC_update at a frame boundary. exp_reg tracks the word DAC_register
//   must hold. Inputs change on the falling edge; outputs are read there too.
module tb_dac_sample_source;

    localparam logic [31:0] MS_WAIT = 32'd99;

    logic        dataclk;
    logic        reset;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [4:0]  stream_sel;
    logic [4:0]  channel_sel;
    logic [15:0] DAC_manual;
    logic [2:0]  gain;
    logic [6:0]  noise_suppress;
`ifdef DAC_SAMPLE_HOLDOFF_EN
    logic        hold_off;
`endif
    logic [15:0] DAC_register;
    logic        DAC_update;

    dac_sample_source_if sample_bus ();

    dac_sample_source dut (
        .dataclk        (dataclk),
        .reset          (reset),
        .main_state     (main_state),
        .channel        (channel),
        .sample_bus     (sample_bus),
        .stream_sel     (stream_sel),
        .channel_sel    (channel_sel),
        .DAC_manual     (DAC_manual),
        .gain           (gain),
        .noise_suppress (noise_suppress),
`ifdef DAC_SAMPLE_HOLDOFF_EN
        .hold_off       (hold_off),
`endif
        .DAC_register   (DAC_register),
        .DAC_update     (DAC_update)
    );

    // clock / reset
    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    // scoreboard
    logic [15:0] exp_q[$];
    logic [15:0] exp_reg;
    int          n_cmp;
    int          n_bad;

    // ------------------------------------------------------------------
    // driver tasks (called on a falling edge, return on a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge dataclk);
    endtask

    task automatic send(input logic [15:0] s, input logic [4:0] st, input logic [4:0] ch);
        sample_bus.sample_in      = s;
        sample_bus.sample_stream  = st;
        sample_bus.sample_channel = ch;
        sample_bus.sample_valid   = 1'b1;
        @(negedge dataclk);
        sample_bus.sample_valid   = 1'b0;
    endtask

    // One-cycle frame boundary; returns the outputs right after it and one
    // cycle later.
    task automatic frame(output logic upd, output logic [15:0] r, output logic upd_after);
        main_state = MS_WAIT;
        channel    = 6'd0;
        @(negedge dataclk);
        upd        = DAC_update;
        r          = DAC_register;
        main_state = 32'd5;
        channel    = 6'd1;
        @(negedge dataclk);
        upd_after  = DAC_update;
    endtask

    // ------------------------------------------------------------------
    // tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic u, ua;
        logic [15:0] r;
        reset = 1'b1;
        tick(2);
        n_cmp++;
        if (DAC_register !== 16'h8000) begin
            n_bad++; $display("FAIL reset_reg: got %h want 8000", DAC_register);
        end
        n_cmp++;
        if (DAC_update !== 1'b0) begin
            n_bad++; $display("FAIL reset_upd: got %b want 0", DAC_update);
        end
        reset = 1'b0;
        exp_reg = 16'h8000;
        tick(2);
        frame(u, r, ua);
        n_cmp++;
        if (u !== 1'b0 || r !== exp_reg) begin
            n_bad++; $display("FAIL reset_empty_frame: upd %b reg %h want upd 0 reg %h", u, r, exp_reg);
        end
    endtask

    task automatic test_basic();
        logic u, ua;
        logic [15:0] r;
        stream_sel = 5'd2; channel_sel = 5'd5; gain = 3'd0; noise_suppress = 7'd0;
        send(16'h9234, 5'd2, 5'd5);
        exp_q.push_back(16'h9234);
        tick(3);
        frame(u, r, ua);
        n_cmp++;
        if (u !== 1'b1) begin
            n_bad++; $display("FAIL basic_upd: got %b want 1", u);
        end
        if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
        n_cmp++;
        if (r !== exp_reg) begin
            n_bad++; $display("FAIL basic_reg: got %h want %h", r, exp_reg);
        end
        n_cmp++;
        if (ua !== 1'b0) begin
            n_bad++; $display("FAIL basic_pulse_width: upd after %b want 0", ua);
        end
    endtask

    task automatic test_reset_mid_pipeline();
        logic u, ua;
        logic [15:0] r;
        send(16'h9500, 5'd2, 5'd5);
        reset = 1'b1;
        #1;
        exp_reg = 16'h8000;
        exp_q.delete();
        n_cmp++;
        if (DAC_register !== exp_reg || DAC_update !== 1'b0) begin
            n_bad++; $display("FAIL midreset_immediate: reg %h upd %b want 8000 0", DAC_register, DAC_update);
        end
        tick(1);
        reset = 1'b0;
        tick(3);
        frame(u, r, ua);
        n_cmp++;
        if (u !== 1'b0 || r !== exp_reg) begin
            n_bad++; $display("FAIL midreset_flushed: upd %b reg %h want 0 %h", u, r, exp_reg);
        end
    endtask

    task automatic test_gain();
        logic [2:0]  g_t[3] = '{3'd3, 3'd7, 3'd7};
        logic [15:0] s_t[3] = '{16'h8100, 16'h9000, 16'h7000};
        logic [15:0] e_t[3] = '{16'h8800, 16'hFFFF, 16'h0000};
        logic u, ua;
        logic [15:0] r;
        noise_suppress = 7'd0;
        for (int i = 0; i < 3; i++) begin
            gain = g_t[i];
            send(s_t[i], 5'd2, 5'd5);
            exp_q.push_back(e_t[i]);
            tick(3);
            frame(u, r, ua);
            n_cmp++;
            if (u !== 1'b1) begin
                n_bad++; $display("FAIL gain_upd[%0d]: got %b want 1", i, u);
            end
            if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
            n_cmp++;
            if (r !== exp_reg) begin
                n_bad++; $display("FAIL gain_reg[%0d]: got %h want %h", i, r, exp_reg);
            end
        end
        gain = 3'd0;
    endtask

    task automatic test_deadband();
        logic [15:0] s_t[3] = '{16'h803F, 16'h8040, 16'h7FC0};
        logic [15:0] e_t[3] = '{16'h8000, 16'h8040, 16'h7FC0};
        logic u, ua;
        logic [15:0] r;
        gain = 3'd0;
        noise_suppress = 7'd4;
        for (int i = 0; i < 3; i++) begin
            send(s_t[i], 5'd2, 5'd5);
            exp_q.push_back(e_t[i]);
            tick(3);
            frame(u, r, ua);
            n_cmp++;
            if (u !== 1'b1) begin
                n_bad++; $display("FAIL dead_upd[%0d]: got %b want 1", i, u);
            end
            if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
            n_cmp++;
            if (r !== exp_reg) begin
                n_bad++; $display("FAIL dead_reg[%0d]: got %h want %h", i, r, exp_reg);
            end
        end
        noise_suppress = 7'd0;
    endtask

    // Second sample's pending write lands on the commit edge.
    task automatic test_race();
        logic u, ua;
        logic [15:0] r;
        send(16'h8111, 5'd2, 5'd5);
        exp_q.push_back(16'h8111);
        tick(3);
        send(16'h8222, 5'd2, 5'd5);
        exp_q.push_back(16'h8222);
        tick(1);
        frame(u, r, ua);
        if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
        n_cmp++;
        if (u !== 1'b1 || r !== exp_reg) begin
            n_bad++; $display("FAIL race_old: upd %b reg %h want 1 %h", u, r, exp_reg);
        end
        tick(3);
        frame(u, r, ua);
        if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
        n_cmp++;
        if (u !== 1'b1 || r !== exp_reg) begin
            n_bad++; $display("FAIL race_new: upd %b reg %h want 1 %h", u, r, exp_reg);
        end
    endtask

    task automatic test_nonmatch();
        logic u, ua;
        logic [15:0] r;
        send(16'hAAAA, 5'd3, 5'd5);
        send(16'hBBBB, 5'd2, 5'd6);
        send(16'hCCCC, 5'd3, 5'd6);
        tick(3);
        frame(u, r, ua);
        n_cmp++;
        if (u !== 1'b0) begin
            n_bad++; $display("FAIL nonmatch_upd: got %b want 0", u);
        end
        n_cmp++;
        if (r !== exp_reg) begin
            n_bad++; $display("FAIL nonmatch_reg: got %h want %h", r, exp_reg);
        end
    endtask

    task automatic test_random();
        logic u, ua;
        logic [15:0] r;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            s = 16'($urandom_range(0, 65535));
            send(s, 5'd2, 5'd5);
            exp_q.push_back(s);
            tick(3);
            frame(u, r, ua);
            if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
            n_cmp++;
            if (u !== 1'b1 || r !== exp_reg) begin
                n_bad++; $display("FAIL random[%0d]: upd %b reg %h want 1 %h", i, u, r, exp_reg);
            end
        end
    endtask

`ifdef DAC_SAMPLE_HOLDOFF_EN
    task automatic test_holdoff();
        logic u, ua;
        logic [15:0] r;
        hold_off = 1'b1;
        send(16'h8ABC, 5'd2, 5'd5);
        exp_q.push_back(16'h8ABC);
        tick(3);
        frame(u, r, ua);
        n_cmp++;
        if (u !== 1'b0 || r !== exp_reg) begin
            n_bad++; $display("FAIL holdoff_held: upd %b reg %h want 0 %h", u, r, exp_reg);
        end
        hold_off = 1'b0;
        tick(1);
        frame(u, r, ua);
        if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
        n_cmp++;
        if (u !== 1'b1 || r !== exp_reg) begin
            n_bad++; $display("FAIL holdoff_release: upd %b reg %h want 1 %h", u, r, exp_reg);
        end
    endtask
`endif

    // Manual value is injected at one frame boundary and committed at the
    // next; gain must not touch it.
    task automatic test_manual();
        logic u, ua;
        logic [15:0] r;
        stream_sel = 5'd31;
        DAC_manual = 16'h1234;
        gain       = 3'd7;
        noise_suppress = 7'd4;
        tick(1);
        frame(u, r, ua);
        exp_q.push_back(16'h1234);
        n_cmp++;
        if (u !== 1'b0 || r !== exp_reg) begin
            n_bad++; $display("FAIL manual_inject_frame: upd %b reg %h want 0 %h", u, r, exp_reg);
        end
        tick(3);
        frame(u, r, ua);
        if (exp_q.size() != 0) exp_reg = exp_q.pop_front();
        n_cmp++;
        if (u !== 1'b1 || r !== exp_reg) begin
            n_bad++; $display("FAIL manual_commit: upd %b reg %h want 1 %h", u, r, exp_reg);
        end
    endtask

    // ------------------------------------------------------------------
    // sequence and report
    // ------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_reg = 16'h8000;
        reset = 1'b1;
        main_state = 32'd5;
        channel = 6'd1;
        stream_sel = 5'd2;
        channel_sel = 5'd5;
        DAC_manual = 16'h0000;
        gain = 3'd0;
        noise_suppress = 7'd0;
`ifdef DAC_SAMPLE_HOLDOFF_EN
        hold_off = 1'b0;
`endif
        sample_bus.sample_in = 16'h0000;
        sample_bus.sample_valid = 1'b0;
        sample_bus.sample_stream = 5'd0;
        sample_bus.sample_channel = 5'd0;
        @(negedge dataclk);

        test_reset();
        test_basic();
        test_reset_mid_pipeline();
        test_gain();
        test_deadband();
        test_race();
        test_nonmatch();
        test_random();
`ifdef DAC_SAMPLE_HOLDOFF_EN
        test_holdoff();
`endif
        test_manual();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
